// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared mode encodings and select-width helper for scan_mux
package scan_mux_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/scan_dwell_cnt.sv
// scan_dwell_cnt: dwell counter and round-robin channel advance for auto-scan
module scan_dwell_cnt
  import scan_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int SEL_W = clog2_min1(N_CH),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] dwell,
  input  logic [SEL_W-1:0] cur_sel,
  input  logic [SEL_W-1:0] load_sel,
  output logic [SEL_W-1:0] sel_next,
  output logic             wrap
);
  logic [CNT_W-1:0] cnt, lim;
  logic adv, last;
  // >= rather than == so a dwell shortened mid-scan advances at once
  assign lim  = (dwell == '0) ? '0 : dwell - 1'b1;
  assign adv  = cnt >= lim;
  assign last = cur_sel == SEL_W'(N_CH - 1);
  assign sel_next = (mode == MODE_MANUAL) ? load_sel :
                    !adv ? cur_sel : last ? '0 : cur_sel + 1'b1;
  assign wrap = en && mode == MODE_AUTO && adv && last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (en) cnt <= (mode == MODE_MANUAL || adv) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered N-channel mux with manual select and auto-scan modes
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int SEL_W = clog2_min1(N_CH),
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_in,
  input  logic [CNT_W-1:0]  dwell,
  input  logic [N_CH*W-1:0] din,
  output logic [W-1:0]      mux_out,
  output logic [SEL_W-1:0]  cur_sel,
  output logic              sel_err,
  output logic              wrap
);
  logic [SEL_W-1:0] sel_next, load_sel;
  logic err, wrap_c, wrap_q;
  assign err      = mode == MODE_MANUAL && int'(sel_in) >= N_CH;
  assign load_sel = err ? cur_sel : sel_in;
  scan_dwell_cnt #(.N_CH(N_CH), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dwell(dwell),
    .cur_sel(cur_sel), .load_sel(load_sel), .sel_next(sel_next), .wrap(wrap_c)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mux_out <= '0;
      cur_sel <= '0;
      sel_err <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (en) begin
      mux_out <= err ? '0 : din[int'(sel_next)*W +: W];
      cur_sel <= sel_next;
      sel_err <= err;
      wrap_q  <= wrap_c;
    end else wrap_q <= 1'b0;
  // pulse must vanish as soon as the block is frozen
  assign wrap = wrap_q & en;
endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
Parametrised, registered N-channel multiplexer. It replaces the fixed 8-to-1 combinational mux used in the lab datapath.
- Manual mode: an externally supplied select chooses the channel.
- Auto-scan mode: an internal sequencer dwells a programmable number of cycles on each channel, then advances round-robin. Each full sweep is flagged.
- Sits between the switch and sensor bank and the display and serial path, so one output can time-share all inputs.

Parameters:
- N_CH, 8, number of input channels (2..16).
- W, 1, data width per channel in bits.
- SEL_W, $clog2(N_CH), select width (derived; do not override).
- CNT_W, 8, width of the dwell counter and of the dwell input.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  global enable; 0 freezes all state.
- mode  input  1  0 = manual select, 1 = auto-scan.
- sel_in  input  SEL_W  manual channel select.
- dwell  input  CNT_W  cycles per channel in auto mode; 0 is treated as 1.
- din  input  N_CH*W  packed channel data; channel k occupies din[k*W +: W].
- mux_out  output  W  registered selected data.
- cur_sel  output  SEL_W  channel currently driving mux_out.
- sel_err  output  1  registered; manual sel_in is >= N_CH.
- wrap  output  1  one-cycle pulse when auto-scan advances from N_CH-1 to 0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. On rst_n=0 the block immediately sets mux_out=0, cur_sel=0, sel_err=0, wrap=0, and dwell count=0. After reset deasserts, the first update happens on the next rising clk edge.
- Data path: mux_out <= din[cur_sel_next] at every clk edge with en=1. Latency from din or sel_in to mux_out is 1 cycle.
- en=0: all registers hold their values, including mux_out, and wrap is forced to 0. Input changes while en=0 are ignored.
- Manual mode (mode=0):
  - cur_sel <= sel_in. The dwell counter is held at 0.
  - If sel_in >= N_CH (possible when N_CH is not a power of 2): mux_out <= 0, sel_err <= 1, cur_sel holds its previous value.
  - Otherwise sel_err <= 0.
  - wrap is always 0 in manual mode.
- Auto mode (mode=1):
  - Dwell counter cnt increments each enabled cycle. Effective dwell eff = max(dwell, 1).
  - When cnt == eff-1: cnt <= 0 and cur_sel advances by 1.
  - When cur_sel == N_CH-1 it wraps to 0, and wrap=1 for exactly that cycle.
  - sel_err <= 0.
- Mode change:
  - Manual to auto: scanning starts from the current cur_sel with cnt=0. The first advance occurs eff cycles later.
  - Auto to manual: takes effect on the same edge (cur_sel <= sel_in). cnt clears.
- dwell changed mid-scan: the new value applies immediately. If cnt >= new eff-1, the advance fires on that edge, so no count ever exceeds the new dwell.
- Reset mid-scan: scanning restarts at channel 0 with a full dwell period.
- N_CH=2 with dwell=1: cur_sel toggles every cycle and wrap pulses every second cycle.

Decomposition:
- Package scan_mux_pkg holds MODE_MANUAL=1'b0 and MODE_AUTO=1'b1, plus a function clog2_min1 (returns at least 1) used for SEL_W.
- One sub-module, scan_dwell_cnt, contains the dwell counter and channel advance logic.
  - Inputs: en, mode, dwell, load_sel.
  - Outputs: sel_next, wrap.
- The top level contains the data mux, the error check and the output registers.

Test Plan:
1. Reset and manual select, defaults (N_CH=8, W=1), din=8'b1110_0101, mode=0. Step sel_in 0..7 every 3 cycles. mux_out must follow 1,0,1,0,0,1,1,1, each one cycle after its sel_in.
2. Auto scan, dwell=3, din as in test 1, mode=1 from reset.
   - cur_sel holds each value for 3 cycles, sequence 0..7 then 0.
   - wrap=1 only on the 7-to-0 edge, i.e. cycle 24 after the first enabled edge.
3. Enable freeze, auto mode, dwell=2. Drop en for 5 cycles at cur_sel=3. cur_sel, mux_out and the count hold; wrap=0. Scanning resumes from 3 with its remaining dwell.
4. Out-of-range select, N_CH=5, W=4, mode=0.
   - sel_in=6: mux_out=0 and sel_err=1 next cycle, cur_sel unchanged.
   - sel_in=2: sel_err=0 and mux_out=din[11:8].
5. Dwell edge cases, auto mode.
   - dwell=0: cur_sel advances every cycle.
   - Change dwell from 10 to 2 while cnt=5: advance on the next edge, then a 2-cycle dwell.
6. Asynchronous reset mid-scan, auto mode, cur_sel=6. Pulse rst_n low between clock edges. Outputs go to 0 without waiting for clk; after release the scan restarts at channel 0.
